// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and helpers for the parametrised FIFO family.
package fifo_pkg;
    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;
    localparam int DEF_DATA_W     = 8;
    localparam int DEF_DEPTH      = 64;
    localparam int DEF_AE_LEVEL   = 4;
    localparam int DEF_AF_MARGIN  = 4;

    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/sync_fifo_param_if.sv
// sync_fifo_param_if: write/read handshake, status flags and error bundle of the FIFO.
interface sync_fifo_param_if #(
    parameter int DATA_W = fifo_pkg::DEF_DATA_W,
    parameter int DEPTH  = fifo_pkg::DEF_DEPTH
);
    localparam int CNT_W = fifo_pkg::clog2(DEPTH) + 1;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [CNT_W-1:0]  count;
    logic              clr_err;
    logic              overflow;
    logic              underflow;

    modport master (
        output wr_en, wr_data, rd_en, clr_err,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
    modport slave (
        input  wr_en, wr_data, rd_en, clr_err,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/fifo_mem_2p.sv
// fifo_mem_2p: DEPTH x DATA_W storage, synchronous write, asynchronous read, no reset.
module fifo_mem_2p #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = fifo_pkg::clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with level flags, occupancy,
// optional first-word-fall-through read and sticky overflow/underflow.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = DEPTH - DEF_AF_MARGIN,
    parameter int AE_LEVEL = DEF_AE_LEVEL,
    parameter int FWFT     = FIFO_MODE_STD
) (
    input logic              clk,
    input logic              reset,
    sync_fifo_param_if.slave bus
);
    localparam int ADDR_W = clog2(DEPTH);
    localparam logic [ADDR_W:0] AF_CNT = (ADDR_W + 1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_CNT = (ADDR_W + 1)'(AE_LEVEL);

    logic [ADDR_W:0]   wr_ptr, rd_ptr, cnt;
    logic              full, empty, wr_acc, rd_acc;
    logic [DATA_W-1:0] head, rd_data_q;
    logic              rd_valid_q, overflow_q, underflow_q;

    // Extra pointer MSB distinguishes full from empty when the address bits match.
    assign cnt    = wr_ptr - rd_ptr;
    assign empty  = wr_ptr == rd_ptr;
    assign full   = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) && (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
    assign wr_acc = bus.wr_en & ~full;
    assign rd_acc = bus.rd_en & ~empty;

    fifo_mem_2p #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr[ADDR_W-1:0]),
        .wdata (bus.wr_data),
        .raddr (rd_ptr[ADDR_W-1:0]),
        .rdata (head)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr      <= wr_ptr + (ADDR_W + 1)'(wr_acc);
            rd_ptr      <= rd_ptr + (ADDR_W + 1)'(rd_acc);
            rd_valid_q  <= rd_acc;
            rd_data_q   <= rd_acc ? head : rd_data_q;
            overflow_q  <= (bus.wr_en & full) | (overflow_q & ~bus.clr_err);
            underflow_q <= (bus.rd_en & empty) | (underflow_q & ~bus.clr_err);
        end
    end

    // FWFT shows the head word directly; an empty FIFO presents zero so reset looks clean.
    always_comb begin
        bus.rd_data      = (FWFT == FIFO_MODE_FWFT) ? (empty ? '0 : head) : rd_data_q;
        bus.rd_valid     = (FWFT == FIFO_MODE_FWFT) ? ~empty : rd_valid_q;
        bus.full         = full;
        bus.empty        = empty;
        bus.almost_full  = cnt >= AF_CNT;
        bus.almost_empty = cnt <= AE_CNT;
        bus.count        = cnt;
        bus.overflow     = overflow_q;
        bus.underflow    = underflow_q;
    end
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: drives a standard and an FWFT FIFO with identical stimulus
// and compares both against a queue-based reference model.
module tb_sync_fifo_param;
    localparam int DEPTH = 64;
    localparam int AF = DEPTH - 4;
    localparam int AE = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sync_fifo_param_if #(.DATA_W(8), .DEPTH(DEPTH)) b0();
    sync_fifo_param_if #(.DATA_W(8), .DEPTH(DEPTH)) b1();

    sync_fifo_param #(.DATA_W(8), .DEPTH(DEPTH), .FWFT(0)) dut0 (.clk(clk), .reset(reset), .bus(b0));
    sync_fifo_param #(.DATA_W(8), .DEPTH(DEPTH), .FWFT(1)) dut1 (.clk(clk), .reset(reset), .bus(b1));

    int checks = 0;
    int errors = 0;
    logic [7:0] q[$];
    logic [7:0] m_rd = 8'h00;
    logic       m_rv = 1'b0;
    logic       m_ov = 1'b0;
    logic       m_un = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        int n = q.size();
        logic [7:0] h = 8'h00;
        if (n > 0) h = q[0];
        chk("count0", 32'(b0.count), n);
        chk("count1", 32'(b1.count), n);
        chk("empty0", b0.empty, n == 0);
        chk("empty1", b1.empty, n == 0);
        chk("full0", b0.full, n == DEPTH);
        chk("full1", b1.full, n == DEPTH);
        chk("afull0", b0.almost_full, n >= AF);
        chk("afull1", b1.almost_full, n >= AF);
        chk("aempty0", b0.almost_empty, n <= AE);
        chk("aempty1", b1.almost_empty, n <= AE);
        chk("ovf0", b0.overflow, m_ov);
        chk("ovf1", b1.overflow, m_ov);
        chk("unf0", b0.underflow, m_un);
        chk("unf1", b1.underflow, m_un);
        chk("rvalid_std", b0.rd_valid, m_rv);
        chk("rdata_std", b0.rd_data, m_rd);
        chk("rvalid_fwft", b1.rd_valid, n > 0);
        chk("rdata_fwft", b1.rd_data, h);
    endtask

    task automatic model_step(input logic we, input logic [7:0] wd, input logic re, input logic clr);
        logic f = q.size() == DEPTH;
        logic e = q.size() == 0;
        m_rv = 1'b0;
        if (re && !e) begin
            m_rd = q.pop_front();
            m_rv = 1'b1;
        end
        if (we && !f) q.push_back(wd);
        m_ov = (we && f) || (m_ov && !clr);
        m_un = (re && e) || (m_un && !clr);
    endtask

    task automatic cyc(input logic we, input logic [7:0] wd, input logic re, input logic clr);
        b0.wr_en = we; b0.wr_data = wd; b0.rd_en = re; b0.clr_err = clr;
        b1.wr_en = we; b1.wr_data = wd; b1.rd_en = re; b1.clr_err = clr;
        @(posedge clk);
        model_step(we, wd, re, clr);
        #1;
        check_all();
    endtask

    initial begin
        cyc_init: begin
            b0.wr_en = 0; b0.wr_data = 0; b0.rd_en = 0; b0.clr_err = 0;
            b1.wr_en = 0; b1.wr_data = 0; b1.rd_en = 0; b1.clr_err = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        check_all();
        reset = 1'b0;
        repeat (2) cyc(0, 8'h00, 0, 0);
        // single word, registered read latency
        cyc(1, 8'hA5, 0, 0);
        cyc(0, 8'h00, 1, 0);
        cyc(0, 8'h00, 0, 0);
        // fill to full, overflow attempt, drain in order
        for (int i = 0; i < DEPTH; i++) cyc(1, 8'(i), 0, 0);
        cyc(1, 8'h99, 0, 0);
        cyc(1, 8'h98, 1, 0);
        cyc(1, 8'h40, 0, 0);
        for (int i = 0; i < DEPTH; i++) cyc(0, 8'h00, 1, 0);
        cyc(0, 8'h00, 0, 1);
        // underflow and clear priority
        cyc(0, 8'h00, 1, 0);
        cyc(0, 8'h00, 0, 0);
        cyc(0, 8'h00, 0, 1);
        cyc(0, 8'h00, 1, 0);
        cyc(0, 8'h00, 1, 1);
        cyc(1, 8'h11, 1, 0);
        cyc(0, 8'h00, 1, 1);
        cyc(0, 8'h00, 0, 1);
        // steady count 10 with simultaneous traffic across pointer wrap
        while (q.size() < 10) cyc(1, 8'($urandom), 0, 0);
        for (int i = 0; i < 3 * DEPTH; i++) cyc(1, 8'($urandom), 1, 0);
        // random traffic, alternating fill and drain bias
        for (int i = 0; i < 600; i++) begin
            int wb = ((i / 150) % 2 == 0) ? 70 : 30;
            cyc($urandom_range(0, 99) < wb, 8'($urandom),
                $urandom_range(0, 99) < 100 - wb, $urandom_range(0, 99) < 5);
        end
        while (q.size() > 0) cyc(0, 8'h00, 1, 0);
        cyc(0, 8'h00, 0, 1);
        // FWFT fall-through then asynchronous reset mid-burst
        cyc(1, 8'h3C, 0, 0);
        cyc(0, 8'h00, 0, 0);
        for (int i = 0; i < 5; i++) cyc(1, 8'(8'hC0 + i), i[0], 0);
        cyc(1, 8'h77, 1, 0);
        #2 reset = 1'b1;
        #1;
        q.delete();
        m_rd = 8'h00; m_rv = 1'b0; m_ov = 1'b0; m_un = 1'b0;
        check_all();
        @(posedge clk);
        #1;
        check_all();
        reset = 1'b0;
        cyc(0, 8'h00, 0, 0);
        cyc(1, 8'h5A, 0, 0);
        cyc(0, 8'h00, 1, 0);
        cyc(0, 8'h00, 0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
